// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART TX path: register map,
// status bit positions and transmitter FSM encodings.
package uart_tx_mmio_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_BUSY  = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU-side view of the TX data register: write strobe/byte in, status flags out.
interface uart_tx_mmio_if;
  import uart_tx_mmio_pkg::*;

  byte_t tx_data_in;
  logic  tx_we_in;
  logic  tx_busy_out;
  logic  tx_active_out;
  logic  tx_overflow_out;

  modport master (
    output tx_data_in, tx_we_in,
    input  tx_busy_out, tx_active_out, tx_overflow_out
  );

  modport slave (
    input  tx_data_in, tx_we_in,
    output tx_busy_out, tx_active_out, tx_overflow_out
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO; head entry is presented combinationally.
module uart_tx_fifo
  import uart_tx_mmio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  byte_t                  wr_data,
  input  logic                   rd_en,
  output byte_t                  rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;

  // Full is judged on the registered count, so a pop cannot make room
  // for a write on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter fed by a byte queue behind the MMIO data register.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           txd
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  byte_t         sr;
  logic          overflow;
  logic          bit_end;
  logic          pop;
  byte_t         head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // Pop either from idle or at the end of a stop bit for gap-free frames.
  assign pop = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.tx_we_in),
    .wr_data(bus.tx_data_in),
    .rd_en  (pop),
    .rd_data(head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bus.tx_busy_out     = (fifo_count == CW'(FIFO_DEPTH));
  assign bus.tx_active_out   = (state != ST_IDLE) | (fifo_count != '0);
  assign bus.tx_overflow_out = overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.tx_we_in & fifo_full) overflow <= 1'b1;
      if (state == ST_IDLE) begin
        if (!fifo_empty) begin
          sr       <= head;
          txd      <= 1'b0;
          state    <= ST_START;
          baud_cnt <= '0;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          ST_START: begin
            txd     <= sr[0];
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end else begin
              txd     <= sr[1];
              sr      <= sr >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            if (!fifo_empty) begin
              sr    <= head;
              txd   <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule
